// File: rtl/rst_seq_ctrl_if.sv
// Sequencer <-> sub-block bundle: soft-reset request and ready acks in, per-stage resets and status out.
// master = sequencer side, slave = consumer/stimulus side; no flow control beyond the per-stage ready ack.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 3
) ();
  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  logic               sw_rst_req;
  logic [NUM_DOM-1:0] dom_rdy;
  logic [NUM_DOM-1:0] dom_rst;
  logic [IDX_W-1:0]   cur_stage;
  logic               seq_busy;
  logic               seq_done;
  logic               seq_err;

  modport master (
    input  sw_rst_req, dom_rdy,
    output dom_rst, cur_stage, seq_busy, seq_done, seq_err
  );

  modport slave (
    output sw_rst_req, dom_rdy,
    input  dom_rst, cur_stage, seq_busy, seq_done, seq_err
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Releases NUM_DOM sub-block resets in index order, each after HOLD_CYC cycles and its ready ack; registered outputs.
// Backpressure: a stage waits on its ready ack; with RST_SEQ_TIMEOUT_EN defined a stalled ack ends in a sticky error.
module rst_seq_ctrl #(
  parameter int NUM_DOM  = 3,
  parameter int HOLD_CYC = 16,
  parameter int TO_CYC   = 255,
  parameter int CNT_W    = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rst_seq_ctrl_if.master io_seq
);
  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  if (NUM_DOM < 2 || HOLD_CYC < 1 || HOLD_CYC >= 2**CNT_W || TO_CYC >= 2**CNT_W) begin : g_bad_param
    $error("rst_seq_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_ASSERT,
    S_WAIT,
`ifdef RST_SEQ_TIMEOUT_EN
    S_ERR,
`endif
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [IDX_W-1:0]   r_idx, w_idx, w_idx_inc;
  logic [NUM_DOM-1:0] r_dom_rst, w_dom_rst;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_sw_q;
  logic               w_sw_rise;
  logic               w_rdy_cur;
  logic               w_holding;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);
  logic r_err, w_err;
  logic r_to_ph, w_to_ph;
  // Shared counter: first the hold interval, then (r_to_ph=1) the ready timeout.
  assign w_holding = !r_to_ph && (r_cnt != HOLD_LAST);
`else
  assign w_holding = (r_cnt != HOLD_LAST);
`endif

  assign w_sw_rise = io_seq.sw_rst_req & ~r_sw_q;
  assign w_rdy_cur = io_seq.dom_rdy[r_idx];
  assign w_idx_inc = r_idx + IDX_W'(1);

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_dom_rst = r_dom_rst;
    w_busy    = r_busy;
    w_done    = r_done;
`ifdef RST_SEQ_TIMEOUT_EN
    w_err     = r_err;
    w_to_ph   = r_to_ph;
`endif
    if (w_sw_rise) begin
      w_state   = S_ASSERT;
      w_cnt     = '0;
      w_idx     = '0;
      w_dom_rst = '1;
      w_busy    = 1'b1;
      w_done    = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      w_err     = 1'b0;
      w_to_ph   = 1'b0;
`endif
    end else begin
      case (r_state)
        S_ASSERT: begin
          if (r_cnt == HOLD_LAST) begin
            w_cnt        = '0;
            w_dom_rst[0] = 1'b0;
            w_state      = S_WAIT;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (w_holding) begin
            w_cnt = r_cnt + CNT_W'(1);
          end else if (w_rdy_cur) begin
            w_cnt = '0;
`ifdef RST_SEQ_TIMEOUT_EN
            w_to_ph = 1'b0;
`endif
            if (r_idx == IDX_LAST) begin
              w_state = S_DONE;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_idx                = w_idx_inc;
              w_dom_rst[w_idx_inc] = 1'b0;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (!r_to_ph) begin
            w_to_ph = 1'b1;
            w_cnt   = '0;
          end else if (r_cnt == TO_LAST) begin
            w_state = S_ERR;
            w_err   = 1'b1;
            w_busy  = 1'b0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_dom_rst <= '1;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_sw_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      r_err     <= 1'b0;
      r_to_ph   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_dom_rst <= w_dom_rst;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_sw_q    <= io_seq.sw_rst_req;
`ifdef RST_SEQ_TIMEOUT_EN
      r_err     <= w_err;
      r_to_ph   <= w_to_ph;
`endif
    end
  end

  assign io_seq.dom_rst   = r_dom_rst;
  assign io_seq.cur_stage = r_idx;
  assign io_seq.seq_busy  = r_busy;
  assign io_seq.seq_done  = r_done;
`ifdef RST_SEQ_TIMEOUT_EN
  assign io_seq.seq_err   = r_err;
`else
  assign io_seq.seq_err   = 1'b0;
`endif
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl (NUM_DOM=3, HOLD_CYC=4, TO_CYC=10): vector table, corner sequences, random vs model.
// Build with or without RST_SEQ_TIMEOUT_EN; expectations follow the same macro.
module tb_rst_seq_ctrl;
  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_DOM(N)) u_if ();

  rst_seq_ctrl #(
    .NUM_DOM (N),
    .HOLD_CYC(HOLD),
    .TO_CYC  (TO),
    .CNT_W   (8)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_seq(u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         edges;
    logic       sw;
    logic [2:0] rdy;
    logic [2:0] rst_exp;
    logic [1:0] stg_exp;
    logic       busy_exp;
    logic       done_exp;
  } vec_t;

  vec_t tbl [14];

  // Reference model: number of stages released plus edges elapsed since the last restart/release.
  int   m_rel;
  int   m_age;
  logic m_done;
  logic m_err;
  logic m_swq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] r, input logic [1:0] s,
                         input logic b, input logic d, input logic e);
    chk({tag, ".dom_rst"},   32'(u_if.dom_rst),   32'(r));
    chk({tag, ".cur_stage"}, 32'(u_if.cur_stage), 32'(s));
    chk({tag, ".seq_busy"},  32'(u_if.seq_busy),  32'(b));
    chk({tag, ".seq_done"},  32'(u_if.seq_done),  32'(d));
    chk({tag, ".seq_err"},   32'(u_if.seq_err),   32'(e));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rel = 0; m_age = 0; m_done = 1'b0; m_err = 1'b0; m_swq = 1'b0;
  endtask

  task automatic model_step(input logic sw, input logic [2:0] rdy);
    logic rise;
    rise  = sw & ~m_swq;
    m_swq = sw;
    if (rise) begin
      m_rel = 0; m_age = 0; m_done = 1'b0; m_err = 1'b0;
    end else if (!m_done && !m_err) begin
      m_age++;
      if (m_rel == 0) begin
        if (m_age == HOLD) begin m_rel = 1; m_age = 0; end
      end else if (m_age >= HOLD && rdy[m_rel-1]) begin
        if (m_rel < N) begin m_rel++; m_age = 0; end
        else m_done = 1'b1;
      end
`ifdef RST_SEQ_TIMEOUT_EN
      else if (m_age >= HOLD + TO) begin
        m_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic chk_model(input string tag);
    logic [2:0] r;
    logic [1:0] s;
    for (int i = 0; i < N; i++) r[i] = (i >= m_rel);
    s = (m_rel == 0) ? 2'd0 : 2'(m_rel - 1);
    chk_out(tag, r, s, !m_done && !m_err, m_done, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.sw_rst_req = 1'b0;
    step(2);
    chk_out("reset", 3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic apply_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      u_if.sw_rst_req = tbl[i].sw;
      u_if.dom_rdy    = tbl[i].rdy;
      step(tbl[i].edges);
      chk_out($sformatf("tbl[%0d]", i), tbl[i].rst_exp, tbl[i].stg_exp,
              tbl[i].busy_exp, tbl[i].done_exp, 1'b0);
    end
  endtask

  initial begin
    logic       sw_r;
    logic [2:0] rdy_r;

    // Nominal release (edges 3,4,7,8,12,15,16 after reset drop).
    tbl[0]  = '{3, 1'b0, 3'b111, 3'b111, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1, 1'b0, 3'b111, 3'b110, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{3, 1'b0, 3'b111, 3'b110, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{1, 1'b0, 3'b111, 3'b100, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{4, 1'b0, 3'b111, 3'b000, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{3, 1'b0, 3'b111, 3'b000, 2'd2, 1'b1, 1'b0};
    tbl[6]  = '{1, 1'b0, 3'b111, 3'b000, 2'd2, 1'b0, 1'b1};
    // Soft reset held 3 cycles from DONE: a single restart, release 4 edges later.
    tbl[7]  = '{1, 1'b1, 3'b111, 3'b111, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{2, 1'b1, 3'b111, 3'b111, 2'd0, 1'b1, 1'b0};
    tbl[9]  = '{1, 1'b0, 3'b111, 3'b111, 2'd0, 1'b1, 1'b0};
    tbl[10] = '{1, 1'b0, 3'b111, 3'b110, 2'd0, 1'b1, 1'b0};
    tbl[11] = '{4, 1'b0, 3'b111, 3'b100, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{4, 1'b0, 3'b111, 3'b000, 2'd2, 1'b1, 1'b0};
    tbl[13] = '{4, 1'b0, 3'b111, 3'b000, 2'd2, 1'b0, 1'b1};

    u_if.sw_rst_req = 1'b0;
    u_if.dom_rdy    = 3'b111;

    do_reset();
    apply_tbl(0, 13);

    // Stage 1 ack withheld until edge 20; stale drop of rdy[0] must be ignored.
    do_reset();
    u_if.dom_rdy = 3'b101;
    step(8);
    chk_out("stall.e8", 3'b100, 2'd1, 1'b1, 1'b0, 1'b0);
    u_if.dom_rdy = 3'b100;
    step(11);
    chk_out("stall.e19", 3'b100, 2'd1, 1'b1, 1'b0, 1'b0);
    u_if.dom_rdy = 3'b110;
    step(1);
    chk_out("stall.e20", 3'b000, 2'd2, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_out("stall.e24", 3'b000, 2'd2, 1'b0, 1'b1, 1'b0);

    // Async reset mid-sequence, then the nominal timing again.
    do_reset();
    u_if.dom_rdy = 3'b111;
    apply_tbl(0, 3);
    #3 rst = 1'b1;
    #1 chk_out("async_rst", 3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    apply_tbl(0, 6);

    // Soft-reset rise during the initial hold restarts the count.
    do_reset();
    u_if.dom_rdy = 3'b111;
    step(1);
    u_if.sw_rst_req = 1'b1;
    step(1);
    chk_out("sw_assert.e2", 3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    u_if.sw_rst_req = 1'b0;
    step(2);
    chk_out("sw_assert.e4", 3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_out("sw_assert.e5", 3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_out("sw_assert.e6", 3'b110, 2'd0, 1'b1, 1'b0, 1'b0);

    // Stage 0 never acks: timeout at edge 18 when enabled, indefinite wait otherwise.
    do_reset();
    u_if.dom_rdy = 3'b000;
    step(17);
    chk_out("to.e17", 3'b110, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1);
`ifdef RST_SEQ_TIMEOUT_EN
    chk_out("to.e18", 3'b110, 2'd0, 1'b0, 1'b0, 1'b1);
    u_if.dom_rdy = 3'b111;
    step(3);
    chk_out("to.sticky", 3'b110, 2'd0, 1'b0, 1'b0, 1'b1);
`else
    chk_out("to.e18", 3'b110, 2'd0, 1'b1, 1'b0, 1'b0);
    step(40);
    chk_out("to.e58", 3'b110, 2'd0, 1'b1, 1'b0, 1'b0);
    u_if.dom_rdy = 3'b111;
`endif
    u_if.sw_rst_req = 1'b1;
    step(1);
    chk_out("to.sw", 3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    u_if.sw_rst_req = 1'b0;
    step(4);
    chk_out("to.restart", 3'b110, 2'd0, 1'b1, 1'b0, 1'b0);

    // Random soak against the model.
    do_reset();
    sw_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      sw_r = ($urandom_range(0, 24) == 0) || (sw_r && ($urandom_range(0, 2) != 0));
      if ((i / 400) % 2 == 1)
        rdy_r = 3'($urandom) & 3'($urandom) & 3'($urandom);
      else
        rdy_r = 3'($urandom) | 3'($urandom);
      u_if.sw_rst_req = sw_r;
      u_if.dom_rdy    = rdy_r;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        step(1);
        model_reset();
        chk_model($sformatf("rnd[%0d].rst", i));
        rst = 1'b0;
      end else begin
        step(1);
        model_step(sw_r, rdy_r);
        chk_model($sformatf("rnd[%0d]", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
